rr_arbiter_4: RTL and testbench

- Four-requester round-robin arbiter that shares one multi-cycle resource, such as a memory bank or functional unit.
- Priority is held in a 2-bit rotating pointer that wraps modulo 4.
- A per-grant hold counter bounds occupancy, so no requester starves.
- Sits between requesting pipeline stages and the shared resource. Drives a registered one-hot grant.

---
 rtl/rr_arbiter_4.sv | 130 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded per-grant hold time.
// Grant is registered and one-hot; a rotating pointer sets search priority.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              arb_clr,
    input  logic [3:0]        req,
    output logic [3:0]        grant,
    output logic              grant_valid,
    output logic [1:0]        grant_id,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              err
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]        state_q, state_d;
    logic [3:0]        grant_q, grant_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [3:0] cand;
    logic [1:0] idx;
    logic [1:0] winner;
    logic       found;
    logic       owner_req;
    logic       take;

    // The owner's own bit is masked so preemption can never re-pick it.
    assign cand      = req & ~grant_q;
    assign owner_req = |(req & grant_q);

    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;
        if (arb_clr) begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            ptr_d   = 2'd0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en && found) begin
                        take = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req) begin
                        if (en && found) begin
                            take = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = 4'b0000;
                            hold_d  = '0;
                        end
                    end else if (en && found && (hold_q == HOLD_LAST)) begin
                        take = 1'b1;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                    hold_d  = '0;
                end
            endcase
            if (take) begin
                state_d = ST_BUSY;
                grant_d = 4'(1) << winner;
                ptr_d   = winner + 2'd1;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        grant_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) begin
                grant_id = 2'(i);
            end
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign hold_cnt    = hold_q;
    assign err         = ((state_q != ST_IDLE) && (state_q != ST_BUSY)) ||
                         (|(grant_q & (grant_q - 4'd1)));

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: hand-derived vector table, corner sequences and
// randomized traffic against an owner/pointer reference model (MAX_HOLD 4 and 1).
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic       arb_clr;
    logic [3:0] req;

    logic [3:0] g0, g1;
    logic       v0, v1;
    logic [1:0] id0, id1;
    logic [3:0] h0;
    logic [0:0] h1;
    logic       e0, e1;

    int n_checks = 0;
    int n_errs   = 0;

    rr_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .arb_clr(arb_clr), .req(req),
        .grant(g0), .grant_valid(v0), .grant_id(id0), .hold_cnt(h0), .err(e0)
    );

    rr_arbiter_4 #(.MAX_HOLD(1), .HOLD_W(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .arb_clr(arb_clr), .req(req),
        .grant(g1), .grant_valid(v1), .grant_id(id1), .hold_cnt(h1), .err(e1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), next-priority index, hold count.
    int mh [2] = '{4, 1};
    int m_owner [2];
    int m_ptr [2];
    int m_hold [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] r, input int p, input int excl);
        for (int k = 0; k < 4; k++) begin
            int i = (p + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic model_reset(input int d);
        m_owner[d] = -1;
        m_ptr[d]   = 0;
        m_hold[d]  = 0;
    endtask

    task automatic give(input int d, input int w);
        m_owner[d] = w;
        m_ptr[d]   = (w + 1) % 4;
        m_hold[d]  = 0;
    endtask

    task automatic model_step(input int d, input logic e, input logic c, input logic [3:0] r);
        int w = search(r, m_ptr[d], m_owner[d]);
        if (c) begin
            model_reset(d);
        end else if (m_owner[d] < 0) begin
            if (e && w >= 0) give(d, w);
        end else if (!r[m_owner[d]]) begin
            if (e && w >= 0) give(d, w);
            else begin
                m_owner[d] = -1;
                m_hold[d]  = 0;
            end
        end else if (e && w >= 0 && m_hold[d] == mh[d] - 1) begin
            give(d, w);
        end else if (m_hold[d] < mh[d] - 1) begin
            m_hold[d]++;
        end
    endtask

    task automatic compare(input int d, input logic [3:0] g, input logic v, input logic [1:0] id,
                           input logic [3:0] h, input logic e);
        logic [3:0] eg;
        int         eid;
        eg  = (m_owner[d] < 0) ? 4'b0000 : 4'(1 << m_owner[d]);
        eid = (m_owner[d] < 0) ? 0 : m_owner[d];
        check($sformatf("d%0d grant", d), 32'(g), 32'(eg));
        check($sformatf("d%0d grant_valid", d), 32'(v), 32'(eg != 4'b0000));
        check($sformatf("d%0d grant_id", d), 32'(id), 32'(eid));
        check($sformatf("d%0d hold_cnt", d), 32'(h), 32'(m_hold[d]));
        check($sformatf("d%0d err", d), 32'(e), 32'(0));
    endtask

    task automatic tick();
        for (int d = 0; d < 2; d++) begin
            if (!rst) model_reset(d);
            else model_step(d, en, arb_clr, req);
        end
        @(posedge clk);
        #1;
        compare(0, g0, v0, id0, h0, e0);
        compare(1, g1, v1, id1, {3'b000, h1}, e1);
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] req;
        logic [3:0] g;
        logic [3:0] h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic c, input logic [3:0] r,
                       input logic [3:0] g, input logic [3:0] h);
        vec_t v;
        v.en = e; v.clr = c; v.req = r; v.g = g; v.h = h;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; arb_clr = 1'b0; req = 4'b1111;

        // Expected grant/hold for MAX_HOLD=4, one entry per clock from reset.
        for (int r = 0; r < 4; r++)
            for (int h = 0; h < 4; h++)
                add(1'b1, 1'b0, 4'b1111, 4'(1 << r), 4'(h));
        add(1'b1, 1'b0, 4'b1111, 4'b0001, 4'd0);   // wrap back to 0
        add(1'b1, 1'b0, 4'b1001, 4'b0001, 4'd1);
        add(1'b1, 1'b0, 4'b1000, 4'b1000, 4'd0);   // gapless handoff
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0);
        for (int i = 0; i < 10; i++)
            add(1'b1, 1'b0, 4'b0010, 4'b0010, (i < 3) ? 4'(i) : 4'd3);
        add(1'b1, 1'b0, 4'b0100, 4'b0100, 4'd0);
        add(1'b1, 1'b1, 4'b0100, 4'b0000, 4'd0);   // clear resets pointer
        add(1'b1, 1'b0, 4'b1001, 4'b0001, 4'd0);
        for (int i = 0; i < 5; i++)
            add(1'b0, 1'b0, 4'b1111, 4'b0001, (i < 3) ? 4'(i + 1) : 4'd3);
        add(1'b0, 1'b0, 4'b1110, 4'b0000, 4'd0);
        add(1'b0, 1'b0, 4'b1110, 4'b0000, 4'd0);
        add(1'b1, 1'b0, 4'b1110, 4'b0010, 4'd0);
        add(1'b1, 1'b1, 4'b1110, 4'b0000, 4'd0);
        add(1'b1, 1'b0, 4'b0100, 4'b0100, 4'd0);
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 4'd0);

        // Reset held with all requests asserted.
        for (int i = 0; i < 3; i++) tick();
        check("reset grant", 32'(g0), 32'(0));
        check("reset hold_cnt", 32'(h0), 32'(0));
        rst = 1'b1;
        tick();
        check("first grant after reset", 32'(g0), 32'(4'b0001));
        tick();

        // Asynchronous reset mid-grant, observed before any clock edge.
        #3;
        rst = 1'b0;
        #1;
        check("async reset grant", 32'(g0), 32'(0));
        check("async reset grant_valid", 32'(v0), 32'(0));
        check("async reset grant d1", 32'(g1), 32'(0));
        model_reset(0);
        model_reset(1);
        req = 4'b0000;
        tick();
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en      = tbl[i].en;
            arb_clr = tbl[i].clr;
            req     = tbl[i].req;
            tick();
            check($sformatf("vec%0d grant", i), 32'(g0), 32'(tbl[i].g));
            check($sformatf("vec%0d hold_cnt", i), 32'(h0), 32'(tbl[i].h));
        end

        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
            en      = ($urandom_range(0, 9) != 0);
            arb_clr = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
